sfp_array: RTL and testbench

SFP_ARRAY -- requirements
Module: sfp_array

---
 rtl/sfp_array.sv | 115 +++++++++++
 tb/tb_sfp_array.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sfp_array.sv
// Per-lane accumulate, then ReLU and threshold gating; SFP_SAT_EN selects saturating vs wrapping adds.
// Latency: result valid one edge after the batch-completing transfer; in_ready drops in POST/EMIT until the result retires.
// Backpressure: out holds in EMIT while out_ready is low.
module sfp_array #(
  parameter int bw     = 8,
  parameter int psum_bw = 16,
  parameter int col    = 8,
  parameter int cnt_bw = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*bw-1:0]      in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [cnt_bw-1:0]      acc_len,
  input  logic [psum_bw-1:0]     thres,
  input  logic                   relu,
  output logic [col*psum_bw-1:0] out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ACC, POST, EMIT} state_t;

  localparam logic [cnt_bw-1:0] one = {{(cnt_bw-1){1'b0}}, 1'b1};

  state_t                          state, state_nxt;
  logic   [cnt_bw-1:0]             count, len, len_in, count_inc;
  logic   [col-1:0][psum_bw-1:0]   acc;

  function automatic logic [psum_bw-1:0] sext(input logic [bw-1:0] s);
    return {{(psum_bw-bw){s[bw-1]}}, s};
  endfunction

  function automatic logic [psum_bw-1:0] add(input logic [psum_bw-1:0] a,
                                             input logic [psum_bw-1:0] b);
`ifdef SFP_SAT_EN
    logic [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    // Extra top bit disagrees with the sign bit only on overflow.
    if (s[psum_bw] != s[psum_bw-1])
      return s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    return s[psum_bw-1:0];
`else
    return a + b;
`endif
  endfunction

  function automatic logic [psum_bw-1:0] post(input logic [psum_bw-1:0] a,
                                              input logic             r,
                                              input logic [psum_bw-1:0] t);
    logic [psum_bw-1:0] v;
    v = a;
    if (r && v[psum_bw-1]) v = '0;
    if ($signed(v) < $signed(t)) v = '0;
    return v;
  endfunction

  assign len_in    = (acc_len == '0) ? one : acc_len;
  assign count_inc = count + one;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = (len_in == one) ? POST : ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && count_inc == len) state_nxt = POST;
      end
      POST: state_nxt = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      len   <= '0;
      acc   <= '0;
      out   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          count <= one;
          len   <= len_in;
          for (int k = 0; k < col; k++) acc[k] <= sext(in[k*bw +: bw]);
        end
        ACC: if (in_valid) begin
          count <= count_inc;
          for (int k = 0; k < col; k++) acc[k] <= add(acc[k], sext(in[k*bw +: bw]));
        end
        POST: for (int k = 0; k < col; k++) out[k*psum_bw +: psum_bw] <= post(acc[k], relu, thres);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sfp_array.sv
// Directed bench for sfp_array: a default-width instance plus a narrow psum_bw=10 instance for overflow behaviour.
module tb_sfp_array;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  in_bus;
  logic         in_valid, in_ready, out_valid, out_ready, busy, relu;
  logic [3:0]   acc_len;
  logic [15:0]  thres;
  logic [127:0] out_bus;

  logic [7:0]   in1;
  logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [3:0]   acc_len1;
  logic [9:0]   out1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sfp_array dut (
    .clk(clk), .reset(reset), .in(in_bus), .in_valid(in_valid), .in_ready(in_ready),
    .acc_len(acc_len), .thres(thres), .relu(relu), .out(out_bus), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  sfp_array #(.bw(8), .psum_bw(10), .col(1), .cnt_bw(4)) dut10 (
    .clk(clk), .reset(reset), .in(in1), .in_valid(in_valid1), .in_ready(in_ready1),
    .acc_len(acc_len1), .thres(10'h200), .relu(1'b0), .out(out1), .out_valid(out_valid1),
    .out_ready(out_ready1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] v);
    in_bus   = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic push1(input logic [7:0] v);
    in1       = v;
    in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
  endtask

  initial begin
    logic [9:0] exp10;
    reset = 1'b0; in_bus = '0; in_valid = 1'b0; out_ready = 1'b0; relu = 1'b0;
    acc_len = 4'd0; thres = 16'h8000;
    in1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b1; acc_len1 = 4'd15;

    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_out",       out_bus,         128'(0));
    reset = 1'b1;
    step();

    // lane0 = 1..10 with acc_len=10; changing acc_len mid-batch must not matter
    acc_len = 4'd10;
    for (int i = 1; i <= 10; i++) begin
      push({56'd0, 8'(i)});
      if (i == 1) acc_len = 4'd2;
      if (i == 5) chk("acc_in_ready", 128'(in_ready), 128'(1));
    end
    chk("sum55_not_yet_valid", 128'(out_valid), 128'(0));
    chk("post_in_ready", 128'(in_ready), 128'(0));
    step();
    chk("sum55_valid", 128'(out_valid), 128'(1));
    chk("sum55_out", out_bus, {112'd0, 16'd55});

    for (int i = 0; i < 5; i++) begin
      chk("hold_valid",    128'(out_valid), 128'(1));
      chk("hold_out",      out_bus, {112'd0, 16'd55});
      chk("hold_in_ready", 128'(in_ready), 128'(0));
      chk("hold_busy",     128'(busy), 128'(1));
      step();
    end
    out_ready = 1'b1;
    step();
    chk("retire_valid", 128'(out_valid), 128'(0));
    chk("retire_busy",  128'(busy), 128'(0));
    chk("retire_keep_out", out_bus, {112'd0, 16'd55});

    // all lanes -5 x4, with idle cycles inside the batch
    acc_len = 4'd4; relu = 1'b0;
    push({8{8'hFB}}); step(); push({8{8'hFB}}); step(); step();
    push({8{8'hFB}}); push({8{8'hFB}});
    step();
    chk("neg20_out", out_bus, {8{16'hFFEC}});
    step();
    relu = 1'b1;
    for (int i = 0; i < 4; i++) push({8{8'hFB}});
    step();
    chk("neg20_relu_valid", 128'(out_valid), 128'(1));
    chk("neg20_relu_out", out_bus, 128'(0));
    step();
    relu = 1'b0;

    // acc_len=0 behaves as a single-sample batch
    acc_len = 4'd0;
    push({8{8'h07}});
    chk("len0_not_yet_valid", 128'(out_valid), 128'(0));
    step();
    chk("len0_valid", 128'(out_valid), 128'(1));
    chk("len0_out", out_bus, {8{16'd7}});
    step();

    // threshold gating on a sum of 55 in lane0
    acc_len = 4'd2;
    thres = 16'd64;
    push({56'd0, 8'd50}); push({56'd0, 8'd5}); step();
    chk("thres64_out", out_bus, 128'(0));
    step();
    thres = 16'd50;
    push({56'd0, 8'd50}); push({56'd0, 8'd5}); step();
    chk("thres50_out", out_bus, {112'd0, 16'd55});
    step();
    thres = 16'd55;
    push({56'd0, 8'd50}); push({56'd0, 8'd5}); step();
    chk("thres_eq_out", out_bus, {112'd0, 16'd55});
    step();
    thres = 16'h8000;

    // 15 x 127 in a 10-bit accumulator
`ifdef SFP_SAT_EN
    exp10 = 10'd511;
`else
    exp10 = 10'h371;
`endif
    out_ready1 = 1'b0;
    for (int i = 0; i < 15; i++) push1(8'd127);
    step();
    chk("psum10_valid", 128'(out_valid1), 128'(1));
    chk("psum10_out", 128'(out1), 128'(exp10));
    out_ready1 = 1'b1;
    step();

    // reset mid-batch discards earlier samples
    acc_len = 4'd8;
    for (int i = 0; i < 3; i++) push({8{8'h05}});
    reset = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out", out_bus, 128'(0));
    #1;
    reset = 1'b1;
    step();
    for (int i = 0; i < 8; i++) push({8{8'h01}});
    step();
    chk("after_rst_valid", 128'(out_valid), 128'(1));
    chk("after_rst_out", out_bus, {8{16'd8}});
    step();
    chk("after_rst_retire", 128'(out_valid), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
